// File: rtl/adf_4360_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adf_4360_pkg
// Description : Shared types and constants for the ADF4360 serial programmer.
// Revision    : 1.0 - initial release
// ============================================================================
package adf_4360_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int unsigned WORD_BITS = 24;

    localparam logic [1:0] WORD_R = 2'd0;
    localparam logic [1:0] WORD_C = 2'd1;
    localparam logic [1:0] WORD_N = 2'd2;

endpackage
`default_nettype wire

// File: rtl/adf_4360_clkdiv.sv
`default_nettype none
// ============================================================================
// Module      : adf_4360_clkdiv
// Description : Half-period tick generator for the serial clock.
// Revision    : 1.0 - initial release
// ============================================================================
module adf_4360_clkdiv #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    logic [7:0] r_cnt;

    // Counter parks at zero while disabled so every word starts a fresh half-period
    assign o_tick = i_en && (r_cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (!i_en || o_tick) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adf_4360.sv
`default_nettype none
// ============================================================================
// Module      : adf_4360
// Description : Shifts R, C and N latch words into an ADF4360 PLL over its
//               3-wire interface, pulsing LE after each word.
// Revision    : 1.0 - initial release
// ============================================================================
module adf_4360
    import adf_4360_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned LE_CYCLES  = 4,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned CN_DELAY   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 trig_i,
    output logic                 ready_o,
    input  logic [WORD_BITS-1:0] R_i,
    input  logic [WORD_BITS-1:0] C_i,
    input  logic [WORD_BITS-1:0] N_i,
    output logic                 sdata_o,
    output logic                 clk_o,
    output logic                 le_o
);

    state_t               r_state,      w_state_nxt;
    logic [1:0]           r_word_idx,   w_word_idx_nxt;
    logic [4:0]           r_bit_idx,    w_bit_idx_nxt;
    logic                 r_phase,      w_phase_nxt;
    logic [15:0]          r_cnt,        w_cnt_nxt;
    logic [WORD_BITS-1:0] r_shadow_r,   w_shadow_r_nxt;
    logic [WORD_BITS-1:0] r_shadow_c,   w_shadow_c_nxt;
    logic [WORD_BITS-1:0] r_shadow_n,   w_shadow_n_nxt;
    logic                 r_ready,      w_ready_nxt;
    logic                 r_sdata,      w_sdata_nxt;
    logic                 r_sclk,       w_sclk_nxt;
    logic                 r_le,         w_le_nxt;

    logic                 w_tick;
    logic [WORD_BITS-1:0] w_cur_word;
    logic                 w_next_msb;

    adf_4360_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_en   (r_state == SHIFT),
        .o_tick (w_tick)
    );

    always_comb begin
        w_cur_word = r_shadow_n;
        w_next_msb = r_shadow_n[WORD_BITS-1];
        case (r_word_idx)
            WORD_R: begin
                w_cur_word = r_shadow_r;
                w_next_msb = r_shadow_c[WORD_BITS-1];
            end
            WORD_C: w_cur_word = r_shadow_c;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_word_idx_nxt = r_word_idx;
        w_bit_idx_nxt  = r_bit_idx;
        w_phase_nxt    = r_phase;
        w_cnt_nxt      = r_cnt;
        w_shadow_r_nxt = r_shadow_r;
        w_shadow_c_nxt = r_shadow_c;
        w_shadow_n_nxt = r_shadow_n;
        w_ready_nxt    = r_ready;
        w_sdata_nxt    = r_sdata;
        w_sclk_nxt     = r_sclk;
        w_le_nxt       = r_le;

        case (r_state)
            IDLE: begin
                if (trig_i) begin
                    w_shadow_r_nxt = R_i;
                    w_shadow_c_nxt = C_i;
                    w_shadow_n_nxt = N_i;
                    w_word_idx_nxt = WORD_R;
                    w_bit_idx_nxt  = 5'(WORD_BITS - 1);
                    w_phase_nxt    = 1'b0;
                    w_sdata_nxt    = R_i[WORD_BITS-1];
                    w_ready_nxt    = 1'b0;
                    w_state_nxt    = SHIFT;
                end
            end

            SHIFT: begin
                if (w_tick) begin
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                        w_sclk_nxt  = 1'b1;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit_idx == 5'd0) begin
                            w_le_nxt    = 1'b1;
                            w_cnt_nxt   = 16'(LE_CYCLES - 1);
                            w_state_nxt = LATCH;
                        end else begin
                            // Data moves on the same edge clk_o falls, so it never changes while high
                            w_bit_idx_nxt = r_bit_idx - 5'd1;
                            w_sdata_nxt   = w_cur_word[r_bit_idx - 5'd1];
                            w_phase_nxt   = 1'b0;
                        end
                    end
                end
            end

            LATCH: begin
                if (r_cnt == 16'd0) begin
                    w_le_nxt = 1'b0;
                    if (r_word_idx == WORD_N) begin
                        w_sdata_nxt = 1'b0;
                        w_ready_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = (r_word_idx == WORD_R) ? 16'(GAP_CYCLES - 1)
                                                             : 16'(CN_DELAY - 1);
                        w_state_nxt = GAP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end

            GAP: begin
                if (r_cnt == 16'd0) begin
                    w_word_idx_nxt = r_word_idx + 2'd1;
                    w_bit_idx_nxt  = 5'(WORD_BITS - 1);
                    w_phase_nxt    = 1'b0;
                    w_sdata_nxt    = w_next_msb;
                    w_state_nxt    = SHIFT;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_word_idx <= WORD_R;
            r_bit_idx  <= 5'd0;
            r_phase    <= 1'b0;
            r_cnt      <= 16'd0;
            r_shadow_r <= '0;
            r_shadow_c <= '0;
            r_shadow_n <= '0;
            r_ready    <= 1'b1;
            r_sdata    <= 1'b0;
            r_sclk     <= 1'b0;
            r_le       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_idx <= w_word_idx_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_phase    <= w_phase_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shadow_r <= w_shadow_r_nxt;
            r_shadow_c <= w_shadow_c_nxt;
            r_shadow_n <= w_shadow_n_nxt;
            r_ready    <= w_ready_nxt;
            r_sdata    <= w_sdata_nxt;
            r_sclk     <= w_sclk_nxt;
            r_le       <= w_le_nxt;
        end
    end

    assign ready_o = r_ready;
    assign sdata_o = r_sdata;
    assign clk_o   = r_sclk;
    assign le_o    = r_le;

endmodule
`default_nettype wire

// File: tb/tb_adf_4360.sv
`default_nettype none
// ============================================================================
// Module      : tb_adf_4360
// Description : Directed self-checking bench for adf_4360 (default and CLK_DIV=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adf_4360;

    localparam int LE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trig1 = 1'b0, trig2 = 1'b0;
    logic [23:0] r1 = '0, c1 = '0, n1 = '0;
    logic [23:0] r2 = '0, c2 = '0, n2 = '0;
    logic ready1, sdata1, sclk1, le1;
    logic ready2, sdata2, sclk2, le2;

    logic sel = 1'b0;
    logic m_ready, m_sdata, m_sclk, m_le;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adf_4360 dut1 (
        .clk_i(clk), .rst_i(rst), .trig_i(trig1), .ready_o(ready1),
        .R_i(r1), .C_i(c1), .N_i(n1),
        .sdata_o(sdata1), .clk_o(sclk1), .le_o(le1)
    );

    adf_4360 #(.CLK_DIV(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .trig_i(trig2), .ready_o(ready2),
        .R_i(r2), .C_i(c2), .N_i(n2),
        .sdata_o(sdata2), .clk_o(sclk2), .le_o(le2)
    );

    assign m_ready = sel ? ready2 : ready1;
    assign m_sdata = sel ? sdata2 : sdata1;
    assign m_sclk  = sel ? sclk2  : sclk1;
    assign m_le    = sel ? le2    : le1;

    // Starts a transfer on the selected DUT and observes it once per cycle on the falling edge
    task automatic run_capture(input int budget, input int retrig_at,
                               output logic [71:0] bits, output int nrise, output int npulse,
                               output int busy, output int le_bad, output int sd_bad,
                               output int c_to_n, output bit timeout);
        logic pclk, psd, ple;
        int len, fall2, rise48;
        bits = '0; nrise = 0; npulse = 0; busy = 0; le_bad = 0; sd_bad = 0;
        c_to_n = -1; timeout = 1'b1; len = 0; fall2 = -1; rise48 = -1;
        pclk = 1'b0; psd = 1'b0; ple = 1'b0;
        if (sel) trig2 = 1'b1; else trig1 = 1'b1;
        @(posedge clk); #1;
        trig1 = 1'b0; trig2 = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (cyc == retrig_at) begin
                trig1 = 1'b1;
                r1 = 24'hFFFFFF;
            end else if (cyc == retrig_at + 1) begin
                trig1 = 1'b0;
            end
            if (m_sclk && !pclk) begin
                bits = {bits[70:0], m_sdata};
                if (nrise == 48) rise48 = cyc;
                nrise++;
            end
            if (m_sclk && pclk && (m_sdata !== psd)) sd_bad++;
            if (m_le && m_sclk) le_bad++;
            if (m_le) len++;
            if (!m_le && ple) begin
                npulse++;
                if (len != LE) le_bad++;
                len = 0;
                if (npulse == 2) fall2 = cyc;
            end
            pclk = m_sclk; psd = m_sdata; ple = m_le;
            if (m_ready) begin
                timeout = 1'b0;
                break;
            end
            busy++;
        end
        if (fall2 >= 0 && rise48 >= 0) c_to_n = rise48 - fall2;
    endtask

    task automatic test_reset;
        #20;
        n_checks++;
        if ({ready1, sdata1, sclk1, le1} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_dut1: got %b expected 1000", {ready1, sdata1, sclk1, le1});
        end
        n_checks++;
        if ({ready2, sdata2, sclk2, le2} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_dut2: got %b expected 1000", {ready2, sdata2, sclk2, le2});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ready1, sdata1, sclk1, le1} !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 1000", {ready1, sdata1, sclk1, le1});
        end
    endtask

    task automatic test_transfer;
        logic [71:0] bits; int nrise, npulse, busy, le_bad, sd_bad, c_to_n; bit to;
        sel = 1'b0;
        r1 = 24'h123456; c1 = 24'h234567; n1 = 24'h345678;
        while ($time < 100) @(negedge clk);
        run_capture(1000, -1, bits, nrise, npulse, busy, le_bad, sd_bad, c_to_n, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL xfer_timeout: ready_o never returned high"); end
        n_checks++;
        if (bits !== 72'h123456_234567_345678) begin
            n_fail++; $display("FAIL xfer_bits: got %h expected 123456234567345678", bits);
        end
        n_checks++;
        if (nrise != 72) begin n_fail++; $display("FAIL xfer_rises: got %0d expected 72", nrise); end
        n_checks++;
        if (npulse != 3) begin n_fail++; $display("FAIL xfer_le_pulses: got %0d expected 3", npulse); end
        n_checks++;
        if (busy != 608) begin n_fail++; $display("FAIL xfer_busy: got %0d expected 608", busy); end
        n_checks++;
        if (le_bad != 0) begin n_fail++; $display("FAIL xfer_le_shape: got %0d bad expected 0", le_bad); end
        n_checks++;
        if (sd_bad != 0) begin n_fail++; $display("FAIL xfer_sdata_stable: got %0d changes expected 0", sd_bad); end
        n_checks++;
        if (c_to_n != 20) begin n_fail++; $display("FAIL xfer_c_to_n: got %0d expected 20", c_to_n); end
    endtask

    task automatic test_retrigger;
        logic [71:0] bits; int nrise, npulse, busy, le_bad, sd_bad, c_to_n; bit to;
        sel = 1'b0;
        r1 = 24'h123456; c1 = 24'h234567; n1 = 24'h345678;
        repeat (2) @(negedge clk);
        run_capture(1000, 50, bits, nrise, npulse, busy, le_bad, sd_bad, c_to_n, to);
        n_checks++;
        if (bits !== 72'h123456_234567_345678) begin
            n_fail++; $display("FAIL retrig_bits: got %h expected 123456234567345678", bits);
        end
        n_checks++;
        if (busy != 608) begin n_fail++; $display("FAIL retrig_busy: got %0d expected 608", busy); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (ready1 !== 1'b1) begin n_fail++; $display("FAIL retrig_stays_idle: got %b expected 1", ready1); end
        r1 = 24'h123456;
    endtask

    task automatic test_back_to_back;
        logic [71:0] bits; int nrise, npulse, busy, le_bad, sd_bad, c_to_n; bit to;
        sel = 1'b0;
        r1 = 24'h0F0F0F; c1 = 24'h800001; n1 = 24'h5A5A5A;
        run_capture(1000, -1, bits, nrise, npulse, busy, le_bad, sd_bad, c_to_n, to);
        n_checks++;
        if (bits !== 72'h0F0F0F_800001_5A5A5A) begin
            n_fail++; $display("FAIL b2b_first_bits: got %h expected 0F0F0F8000015A5A5A", bits);
        end
        r1 = 24'hABCDEF; c1 = 24'h000001; n1 = 24'hC00003;
        run_capture(1000, -1, bits, nrise, npulse, busy, le_bad, sd_bad, c_to_n, to);
        n_checks++;
        if (bits !== 72'hABCDEF_000001_C00003) begin
            n_fail++; $display("FAIL b2b_second_bits: got %h expected ABCDEF000001C00003", bits);
        end
        n_checks++;
        if (busy != 608) begin n_fail++; $display("FAIL b2b_second_busy: got %0d expected 608", busy); end
    endtask

    task automatic test_reset_mid;
        logic [71:0] bits; int nrise, npulse, busy, le_bad, sd_bad, c_to_n; bit to;
        int pulses_before, le_after, not_ready;
        logic ple;
        sel = 1'b0;
        r1 = 24'h123456; c1 = 24'h234567; n1 = 24'h345678;
        repeat (2) @(negedge clk);
        pulses_before = 0; ple = 1'b0;
        trig1 = 1'b1;
        @(posedge clk); #1;
        trig1 = 1'b0;
        // Cycle 300 lies inside the C word's shift phase
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!le1 && ple) pulses_before++;
            ple = le1;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ready1, sdata1, sclk1, le1} !== 4'b1000) begin
            n_fail++; $display("FAIL midreset_outputs: got %b expected 1000", {ready1, sdata1, sclk1, le1});
        end
        n_checks++;
        if (pulses_before != 1) begin
            n_fail++; $display("FAIL midreset_pulses_before: got %0d expected 1", pulses_before);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        le_after = 0; not_ready = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (le1) le_after++;
            if (!ready1) not_ready++;
        end
        n_checks++;
        if (le_after != 0) begin n_fail++; $display("FAIL midreset_no_le: got %0d le cycles expected 0", le_after); end
        n_checks++;
        if (not_ready != 0) begin n_fail++; $display("FAIL midreset_idle: got %0d busy cycles expected 0", not_ready); end
        run_capture(1000, -1, bits, nrise, npulse, busy, le_bad, sd_bad, c_to_n, to);
        n_checks++;
        if (bits !== 72'h123456_234567_345678) begin
            n_fail++; $display("FAIL midreset_rerun_bits: got %h expected 123456234567345678", bits);
        end
        n_checks++;
        if (npulse != 3 || busy != 608) begin
            n_fail++; $display("FAIL midreset_rerun_shape: got pulses=%0d busy=%0d expected 3/608", npulse, busy);
        end
    endtask

    task automatic test_clkdiv1;
        logic [71:0] bits; int nrise, npulse, busy, le_bad, sd_bad, c_to_n; bit to;
        sel = 1'b1;
        r2 = 24'h000000; c2 = 24'hFFFFFF; n2 = 24'hAAAAAA;
        repeat (2) @(negedge clk);
        run_capture(400, -1, bits, nrise, npulse, busy, le_bad, sd_bad, c_to_n, to);
        n_checks++;
        if (bits !== 72'h000000_FFFFFF_AAAAAA) begin
            n_fail++; $display("FAIL div1_bits: got %h expected 000000FFFFFFAAAAAA", bits);
        end
        n_checks++;
        if (busy != 176) begin n_fail++; $display("FAIL div1_busy: got %0d expected 176", busy); end
        n_checks++;
        if (nrise != 72 || npulse != 3) begin
            n_fail++; $display("FAIL div1_counts: got rises=%0d pulses=%0d expected 72/3", nrise, npulse);
        end
        n_checks++;
        if (le_bad != 0 || sd_bad != 0) begin
            n_fail++; $display("FAIL div1_shape: got le_bad=%0d sd_bad=%0d expected 0/0", le_bad, sd_bad);
        end
        n_checks++;
        if (c_to_n != 17) begin n_fail++; $display("FAIL div1_c_to_n: got %0d expected 17", c_to_n); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_transfer();
        test_retrigger();
        test_back_to_back();
        test_reset_mid();
        test_clkdiv1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/adf_4360.md
ADF_4360 -- requirements
Module: adf_4360

Interface
REQ-001 CLK_DIV, 4, system clocks per clk_o half-period; legal range 1..255.
REQ-002 LE_CYCLES, 4, system clocks le_o stays high per latch pulse; legal range 1..255.
REQ-003 GAP_CYCLES, 4, idle system clocks after the R-word latch pulse; legal range 1..65535.
REQ-004 CN_DELAY, 16, idle system clocks after the C-word latch pulse, before the N word; legal range 1..65535.
REQ-005 clk_i  in  1  system clock; all logic on its rising edge; one clock.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 trig_i  in  1  start request, sampled on rising clk_i edges.
REQ-008 ready_o  out  1  high when idle and able to accept trig_i.
REQ-009 R_i  in  24  R-counter latch word.
REQ-010 C_i  in  24  control latch word.
REQ-011 N_i  in  24  N-counter latch word.
REQ-012 sdata_o  out  1  serial data to the PLL DATA pin.
REQ-013 clk_o  out  1  serial clock to the PLL CLK pin; the PLL samples sdata_o on its rising edge.
REQ-014 le_o  out  1  load-enable to the PLL LE pin; active-high pulse.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, LATCH and GAP; the word index SHALL take the values 0=R, 1=C, 2=N.
REQ-016 IDLE: ready_o=1, clk_o=0, le_o=0, sdata_o=0.
REQ-017 A rising clk_i edge with trig_i=1 in IDLE SHALL capture R_i, C_i and N_i into internal shadow registers and enter SHIFT with word index 0; from the next cycle ready_o=0.
REQ-018 trig_i while not in IDLE SHALL be ignored, and input changes after capture SHALL not affect the transfer in progress.
REQ-019 SHIFT SHALL send the current 24-bit word MSB first (bit 23 down to bit 0).
REQ-020 Each bit SHALL hold clk_o=0 for CLK_DIV cycles, then clk_o=1 for CLK_DIV cycles, with sdata_o stable over both phases.
REQ-021 sdata_o SHALL change only while clk_o=0; one word therefore takes 48*CLK_DIV cycles.
REQ-022 After bit 0's high phase, the FSM SHALL enter LATCH: clk_o=0, le_o=1 for LE_CYCLES cycles, sdata_o held at bit 0.
REQ-023 After LATCH of word 0, the FSM SHALL enter GAP for GAP_CYCLES cycles; after LATCH of word 1, GAP for CN_DELAY cycles; in GAP le_o=0 and clk_o=0.
REQ-024 After GAP, the word index SHALL increment and the FSM SHALL return to SHIFT.
REQ-025 After LATCH of word 2, the FSM SHALL go directly to IDLE, with ready_o=1 on the cycle after le_o falls.
REQ-026 Busy duration SHALL be 3*(48*CLK_DIV+LE_CYCLES)+GAP_CYCLES+CN_DELAY cycles; with default parameters this is 608 cycles.
REQ-027 A trig_i in the same cycle that ready_o rises SHALL be accepted, starting a new transfer with no extra idle cycle.
REQ-028 All outputs SHALL be registered and glitch-free.

Reset
REQ-029 rst_i high SHALL immediately force IDLE: ready_o=1, sdata_o=0, clk_o=0, le_o=0, and all counters and shadow registers to 0.
REQ-030 Reset during a transfer SHALL abort it without emitting any further le_o pulse.
REQ-031 Operation SHALL resume on the first rising clk_i edge after rst_i deasserts.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/SHIFT/LATCH/GAP), the word-index constants (R=0, C=1, N=2) and WORD_BITS=24.
REQ-033 One sub-module, adf_4360_clkdiv, SHALL generate the half-period tick from CLK_DIV; all other logic SHALL stay in a single module.

Verification
REQ-034 Default parameters, R_i=24'h123456, C_i=24'h234567, N_i=24'h345678, one-cycle trig_i at 100 ns -> bits sampled on clk_o rising edges reconstruct 123456, 234567, 345678 in that order.
REQ-035 Same stimulus -> exactly 3 le_o pulses, each 4 cycles long and only while clk_o=0, ready_o low for 608 cycles, 72 clk_o rising edges in total.
REQ-036 Same stimulus -> le_o falling edge of the C word to the first clk_o rise of the N word = 16+4 cycles; sdata_o never changes while clk_o=1.
REQ-037 trig_i pulsed again at cycle 50 of a transfer, with R_i changed to 24'hFFFFFF -> ignored, and the R word still shifts out 123456.
REQ-038 rst_i asserted during the C word -> outputs reach their reset values at once, no third le_o pulse occurs, and a new trig_i performs a full, correct transfer.
REQ-039 CLK_DIV=1 with the words 000000, FFFFFF, AAAAAA -> serial stream correct, and busy duration = 3*(48+4)+4+16 = 176 cycles.
